// File: rtl/grasshopper_pkg.sv
// grasshopper_pkg: shared Grasshopper constants, pi / pi^-1 substitution and S-layer state type
package grasshopper_pkg;
  localparam int BLOCK_W = 128;
  localparam int BYTE_W  = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };
  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return PI[b];
  endfunction
  // inverse derived from the forward table so the two can never disagree
  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) r = (PI[i] == b) ? 8'(i) : r;
    return r;
  endfunction
endpackage

// File: rtl/sbox_lane.sv
// sbox_lane: one byte of substitution, forward pi or inverse pi^-1 selected by mode_i
module sbox_lane
  import grasshopper_pkg::*;
(
  input  logic       mode_i,
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);
  assign byte_o = mode_i ? sbox_inv(byte_i) : sbox_fwd(byte_i);
endmodule

// File: rtl/sbox_layer_iter.sv
// sbox_layer_iter: iterative Grasshopper S-layer, LANES bytes per cycle, valid/ready on both sides
module sbox_layer_iter
  import grasshopper_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int OUT_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               mode_i,
  input  logic [BLOCK_W-1:0] data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [BLOCK_W-1:0] data_o,
  output logic               busy_o
);
  localparam int CYC = 16 / LANES;
  localparam int CW  = (CYC > 1) ? $clog2(CYC) : 1;
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sbox_layer_iter: LANES must be 1, 2, 4, 8 or 16");
  end
  if (OUT_REG != 1) begin : g_bad_out_reg
    $error("sbox_layer_iter: OUT_REG must be 1");
  end
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [BLOCK_W-1:0] work_q, work_d, data_q;
  logic               mode_q, accept, last;
  logic [BYTE_W-1:0]  lane_out [LANES];
  assign accept = in_valid_i & in_ready_o;
  assign last   = cnt_q == CW'(CYC - 1);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .mode_i (mode_q),
      .byte_i (work_q[BYTE_W*(int'(cnt_q)*LANES+i) +: BYTE_W]),
      .byte_o (lane_out[i])
    );
  end
  always_comb begin
    work_d = work_q;
    for (int i = 0; i < LANES; i++) work_d[BYTE_W*(int'(cnt_q)*LANES+i) +: BYTE_W] = lane_out[i];
  end
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb
    state_d = (state_q == IDLE) ? (accept ? RUN : IDLE) :
              (state_q == RUN)  ? (last ? DONE : RUN) :
              accept ? RUN : out_ready_i ? IDLE : DONE;
  always_comb begin
    in_ready_o  = (state_q == IDLE) || (state_q == DONE && out_ready_i);
    out_valid_o = state_q == DONE;
    busy_o      = state_q == RUN;
  end
  // data_q only changes when a result completes, so it holds the last result while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      work_q <= '0;
      mode_q <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      work_q <= data_i;
      mode_q <= mode_i;
    end else if (state_q == RUN) begin
      cnt_q  <= last ? '0 : cnt_q + 1'b1;
      work_q <= work_d;
      data_q <= last ? work_d : data_q;
    end
  end
  assign data_o = data_q;
endmodule

// File: tb/tb_sbox_layer_iter.sv
// tb_sbox_layer_iter: five S-layer instances (LANES 4,1,2,8,16) checked against a table model
module tb_sbox_layer_iter;
  localparam int NU = 5;
  localparam int LV [NU] = '{4, 1, 2, 8, 16};
  localparam logic [127:0] V_PT = 128'hffeeddccbbaa99881122334455667700;
  localparam logic [127:0] V_CT = 128'hb66cd8887d38e8d77765aeea0c9a7efc;
  localparam logic [7:0] PI_T [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };
  logic         clk = 1'b0, rst = 1'b1;
  logic         iv [NU], md [NU], ordy [NU];
  logic [127:0] di [NU];
  logic         irdy [NU], ov [NU], busy [NU];
  logic [127:0] dout [NU];
  logic [7:0]   pinv [256];
  int           n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NU; g++) begin : g_dut
    sbox_layer_iter #(.LANES(LV[g]), .OUT_REG(1)) dut (
      .clk(clk), .rst(rst), .in_valid_i(iv[g]), .in_ready_o(irdy[g]), .mode_i(md[g]),
      .data_i(di[g]), .out_valid_o(ov[g]), .out_ready_i(ordy[g]), .data_o(dout[g]), .busy_o(busy[g])
    );
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] ref_layer(input bit m, input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = m ? pinv[d[8*k +: 8]] : PI_T[d[8*k +: 8]];
    return r;
  endfunction
  // offers one block from IDLE with out_ready high; lat counts clock edges from accept to out_valid
  task automatic run_block(input int u, input bit m, input logic [127:0] d,
                           output logic [127:0] r, output int lat, output int bc);
    @(negedge clk);
    iv[u] = 1'b1; md[u] = m; di[u] = d; ordy[u] = 1'b1;
    #1 chk("ready_before_accept", 128'(irdy[u]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    iv[u] = 1'b0; di[u] = ~d; md[u] = ~m;
    lat = 0; bc = 0;
    while (!ov[u] && lat < 64) begin
      bc += busy[u] ? 1 : 0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!ov[u]) chk("timeout_out_valid", 128'(ov[u]), 128'd1);
    r = dout[u];
  endtask
  initial begin
    logic [127:0] r, r2, hold, d;
    int lat, bc;
    bit m;
    for (int i = 0; i < 256; i++) pinv[PI_T[i]] = 8'(i);
    for (int u = 0; u < NU; u++) begin iv[u] = 0; md[u] = 0; di[u] = '0; ordy[u] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      chk("rst_out_valid", 128'(ov[u]), 128'd0);
      chk("rst_busy", 128'(busy[u]), 128'd0);
      chk("rst_in_ready", 128'(irdy[u]), 128'd1);
      chk("rst_data", dout[u], 128'd0);
    end
    rst = 1'b0;
    run_block(0, 0, V_PT, r, lat, bc);
    chk("fwd_vector", r, V_CT);
    chk("fwd_latency", 128'(lat), 128'd4);
    chk("fwd_busy_cycles", 128'(bc), 128'd4);
    run_block(0, 1, V_CT, r, lat, bc);
    chk("inv_vector", r, V_PT);
    run_block(0, 0, 128'd0, r, lat, bc);
    chk("fwd_zero", r, {16{8'hFC}});
    run_block(0, 1, {16{8'hFC}}, r, lat, bc);
    chk("inv_fc", r, 128'd0);
    for (int u = 1; u < NU; u++) begin
      run_block(u, 0, V_PT, r, lat, bc);
      chk("sweep_vector", r, V_CT);
      chk("sweep_latency", 128'(lat), 128'(16 / LV[u]));
      chk("sweep_busy_cycles", 128'(bc), 128'(16 / LV[u]));
    end
    for (int u = 0; u < NU; u++)
      for (int n = 0; n < 8; n++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        m = 1'($urandom_range(0, 1));
        run_block(u, m, d, r, lat, bc);
        chk("random_block", r, ref_layer(m, d));
      end
    // backpressure in DONE, then a back-to-back accept while stray input is offered in RUN
    @(negedge clk);
    iv[0] = 1'b1; md[0] = 1'b0; di[0] = V_PT; ordy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    for (int k = 0; k < 64 && !ov[0]; k++) @(negedge clk);
    chk("bp_reach_done", 128'(ov[0]), 128'd1);
    hold = dout[0];
    chk("bp_result", hold, V_CT);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", 128'(ov[0]), 128'd1);
      chk("bp_data_held", dout[0], hold);
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    ordy[0] = 1'b1; iv[0] = 1'b1; di[0] = d; md[0] = 1'b1;
    #1 chk("b2b_in_ready", 128'(irdy[0]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b1; di[0] = ~d; md[0] = 1'b0; ordy[0] = 1'b0;
    chk("b2b_valid_low", 128'(ov[0]), 128'd0);
    chk("b2b_old_result_held", dout[0], hold);
    chk("run_not_ready", 128'(irdy[0]), 128'd0);
    lat = 0;
    while (!ov[0] && lat < 64) begin @(posedge clk); lat++; @(negedge clk); end
    chk("b2b_latency", 128'(lat), 128'd4);
    chk("b2b_result", dout[0], ref_layer(1, d));
    r = dout[0];
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("drain_valid_low", 128'(ov[0]), 128'd0);
    chk("drain_data_held", dout[0], r);
    // reset while cnt==2 of a LANES=4 block
    iv[0] = 1'b1; md[0] = 1'b0; di[0] = V_PT;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 128'(ov[0]), 128'd0);
    chk("midrst_busy", 128'(busy[0]), 128'd0);
    chk("midrst_ready", 128'(irdy[0]), 128'd1);
    chk("midrst_data", dout[0], 128'd0);
    rst = 1'b0;
    run_block(0, 1, V_CT, r, lat, bc);
    chk("post_rst_block", r, V_PT);
    chk("post_rst_latency", 128'(lat), 128'd4);
    for (int x = 0; x < 256; x++) begin
      d = {16{8'(x)}};
      run_block(4, 0, d, r, lat, bc);
      chk("table_fwd", r, {16{PI_T[x]}});
      run_block(4, 1, r, r2, lat, bc);
      chk("table_roundtrip", r2, d);
      run_block(4, 1, d, r, lat, bc);
      chk("table_inv", r, {16{pinv[x]}});
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
